// File: rtl/apb_req_bridge_pkg.sv
// Shared types for the APB requester: state encoding and bus widths.
// Imported by the interface, the bridge and its timeout counter.
package apb_req_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb_req_bridge_if.sv
// Request/response channel plus APB out_* port of the requester.
// master = bridge view, slave = fabric/completer view.
interface apb_req_bridge_if;
    import apb_req_bridge_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic [PROT_W-1:0] req_prot;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] out_paddr;
    logic [DATA_W-1:0] out_pwdata;
    logic              out_psel;
    logic              out_penable;
    logic              out_pwrite;
    logic [PROT_W-1:0] out_pprot;
    logic [STRB_W-1:0] out_pstrb;
    logic              out_pready;
    logic              out_pslverr;
    logic [DATA_W-1:0] out_prdata;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        input  req_wstrb, req_prot, resp_ready,
        input  out_pready, out_pslverr, out_prdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output out_paddr, out_pwdata, out_psel, out_penable,
        output out_pwrite, out_pprot, out_pstrb
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        output req_wstrb, req_prot, resp_ready,
        output out_pready, out_pslverr, out_prdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  out_paddr, out_pwdata, out_psel, out_penable,
        input  out_pwrite, out_pprot, out_pstrb
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog: counts stalled cycles, flags the last allowed one.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/apb_req_bridge.sv
// APB4 requester: one outstanding valid/ready request -> SETUP/ACCESS.
// Optional ACCESS watchdog under APB_REQ_BRIDGE_TIMEOUT_EN.
module apb_req_bridge
    import apb_req_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clock,
    input logic               reset,
    apb_req_bridge_if.master  bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [PROT_W-1:0] prot_q, prot_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_expired;

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q == SETUP),
        .enable ((state_q == ACCESS) && !bus.out_pready),
        .expired(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        prot_d  = prot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    // APB4: reads carry no strobes
                    wstrb_d = bus.req_write ? bus.req_wstrb : '0;
                    prot_d  = bus.req_prot;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.out_pready) begin
                    rdata_d = write_q ? '0 : bus.out_prdata;
                    err_d   = bus.out_pslverr;
                    state_d = RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.out_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.out_penable = (state_q == ACCESS);
    assign bus.out_paddr   = addr_q;
    assign bus.out_pwrite  = write_q;
    assign bus.out_pwdata  = wdata_q;
    assign bus.out_pstrb   = wstrb_q;
    assign bus.out_pprot   = prot_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge: vector table plus corner sequences.
module tb_apb_req_bridge;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_pstrb;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[4];

    always #5 clock = ~clock;

    apb_req_bridge_if bif();

    apb_req_bridge #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string ph, input vec_t v);
        chk({ph, "_paddr"}, bif.out_paddr, v.addr);
        chk({ph, "_pwdata"}, bif.out_pwdata, v.wdata);
        chk({ph, "_pwrite"}, 32'(bif.out_pwrite), 32'(v.write));
        chk({ph, "_pstrb"}, 32'(bif.out_pstrb), 32'(v.exp_pstrb));
        chk({ph, "_pprot"}, 32'(bif.out_pprot), 32'(v.prot));
    endtask

    // One full transfer starting in IDLE; hold = cycles resp_ready stays low
    task automatic do_xfer(input vec_t v, input int hold);
        chk("idle_req_ready", 32'(bif.req_ready), 1);
        bif.req_valid = 1'b1;
        bif.req_write = v.write;
        bif.req_addr  = v.addr;
        bif.req_wdata = v.wdata;
        bif.req_wstrb = v.wstrb;
        bif.req_prot  = v.prot;
        bif.resp_ready = (hold == 0);
        step();
        bif.req_valid = 1'b0;
        bif.req_addr  = 32'hFFFF_FFFF;
        bif.req_wdata = 32'hFFFF_FFFF;
        bif.req_wstrb = 4'hF;
        bif.req_prot  = 3'h7;
        chk("setup_psel", 32'(bif.out_psel), 1);
        chk("setup_penable", 32'(bif.out_penable), 0);
        chk("setup_req_ready", 32'(bif.req_ready), 0);
        chk_fields("setup", v);
        bif.out_pready = 1'b0;
        step();
        for (int k = 0; k <= v.waits; k++) begin
            chk("access_psel", 32'(bif.out_psel), 1);
            chk("access_penable", 32'(bif.out_penable), 1);
            chk("access_resp_valid", 32'(bif.resp_valid), 0);
            chk_fields("access", v);
            bif.out_pready  = (k == v.waits);
            bif.out_prdata  = (k == v.waits) ? v.prdata : 32'h0BAD_0BAD;
            bif.out_pslverr = (k == v.waits) ? v.slverr : 1'b1;
            step();
        end
        bif.out_pready  = 1'b0;
        bif.out_prdata  = 32'hA5A5_A5A5;
        bif.out_pslverr = 1'b0;
        chk("resp_valid", 32'(bif.resp_valid), 1);
        chk("resp_rdata", bif.resp_rdata, v.exp_rdata);
        chk("resp_err", 32'(bif.resp_err), 32'(v.exp_err));
        chk("resp_psel", 32'(bif.out_psel), 0);
        chk("resp_req_ready", 32'(bif.req_ready), 0);
        for (int h = 0; h < hold; h++) begin
            bif.out_pready = 1'b1;
            step();
            chk("hold_resp_valid", 32'(bif.resp_valid), 1);
            chk("hold_rdata", bif.resp_rdata, v.exp_rdata);
            chk("hold_err", 32'(bif.resp_err), 32'(v.exp_err));
            chk("hold_psel", 32'(bif.out_psel), 0);
            chk("hold_req_ready", 32'(bif.req_ready), 0);
        end
        bif.out_pready = 1'b0;
        bif.resp_ready = 1'b1;
        step();
        chk("done_resp_valid", 32'(bif.resp_valid), 0);
        chk("done_req_ready", 32'(bif.req_ready), 1);
        chk("done_rdata_held", bif.resp_rdata, v.exp_rdata);
    endtask

    initial begin
        vec_t v;
        int   acc;

        vecs[0] = '{1'b0, 32'h1000_0004, 32'h0, 4'h0, 3'h0,
                    32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 32'h2000_0010, 32'h55AA_1234, 4'b0011, 3'h2,
                    32'hFFFF_FFFF, 1'b0, 5, 32'h0, 1'b0, 4'b0011};
        vecs[2] = '{1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 3'h5,
                    32'h1234_5678, 1'b1, 2, 32'h1234_5678, 1'b1, 4'h0};
        vecs[3] = '{1'b1, 32'h4000_0ffc, 32'hCAFE_F00D, 4'hF, 3'h1,
                    32'h7777_7777, 1'b1, 0, 32'h0, 1'b1, 4'hF};

        bif.req_valid   = 1'b0;
        bif.req_write   = 1'b0;
        bif.req_addr    = '0;
        bif.req_wdata   = '0;
        bif.req_wstrb   = '0;
        bif.req_prot    = '0;
        bif.resp_ready  = 1'b1;
        bif.out_pready  = 1'b1;
        bif.out_pslverr = 1'b1;
        bif.out_prdata  = 32'h9999_9999;

        step();
        step();
        chk("rst_req_ready", 32'(bif.req_ready), 1);
        chk("rst_resp_valid", 32'(bif.resp_valid), 0);
        chk("rst_resp_rdata", bif.resp_rdata, 0);
        chk("rst_resp_err", 32'(bif.resp_err), 0);
        chk("rst_psel", 32'(bif.out_psel), 0);
        chk("rst_penable", 32'(bif.out_penable), 0);
        chk("rst_paddr", bif.out_paddr, 0);
        chk("rst_pwdata", bif.out_pwdata, 0);
        chk("rst_pstrb", 32'(bif.out_pstrb), 0);
        chk("rst_pprot", 32'(bif.out_pprot), 0);
        chk("rst_pwrite", 32'(bif.out_pwrite), 0);
        reset = 1'b0;
        step();
        chk("idle_pready_ignored", 32'(bif.out_psel), 0);
        bif.out_pready  = 1'b0;
        bif.out_pslverr = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_xfer(vecs[i], 0);
        end

        do_xfer(vecs[2], 10);

        // reset pulsed while in ACCESS drops the transfer
        bif.req_valid = 1'b1;
        bif.req_write = 1'b0;
        bif.req_addr  = 32'h5000_0000;
        step();
        bif.req_valid = 1'b0;
        step();
        chk("pre_rst_penable", 32'(bif.out_penable), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_psel", 32'(bif.out_psel), 0);
        chk("mid_rst_penable", 32'(bif.out_penable), 0);
        chk("mid_rst_resp_valid", 32'(bif.resp_valid), 0);
        chk("mid_rst_req_ready", 32'(bif.req_ready), 1);
        do_xfer(vecs[0], 0);

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
        v = vecs[0];
        bif.req_valid = 1'b1;
        bif.req_write = 1'b0;
        bif.req_addr  = v.addr;
        bif.resp_ready = 1'b0;
        bif.out_pready = 1'b0;
        step();
        bif.req_valid = 1'b0;
        step();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (bif.out_penable) begin
                acc++;
                step();
            end
        end
        chk("tmo_access_cycles", 32'(acc), 8);
        chk("tmo_resp_valid", 32'(bif.resp_valid), 1);
        chk("tmo_resp_err", 32'(bif.resp_err), 1);
        chk("tmo_resp_rdata", bif.resp_rdata, 0);
        chk("tmo_psel", 32'(bif.out_psel), 0);
        bif.resp_ready = 1'b1;
        step();
        chk("tmo_done_req_ready", 32'(bif.req_ready), 1);
`else
        v = vecs[1];
        acc = v.waits;
        do_xfer(v, acc - 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_bridge.md
# apb_req_bridge

APB requester: turns a simple valid/ready request/response channel from the CPU-side fabric into APB4 SETUP/ACCESS transfers on an `out_*` APB port. It sits upstream of the APB delayer and peripheral completers, driving the same `out_*` signal set the completers expect. One transfer is outstanding at a time. Read data and the error flag are returned on a registered response channel.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: ACCESS-phase cycle limit. Used only when `APB_REQ_BRIDGE_TIMEOUT_EN` is defined. Must be ≥ 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_addr`  in  32  byte address.
- `req_write`  in  1  1 = write.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte strobes.
- `req_prot`  in  3  protection attributes.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed.
- `resp_rdata`  out  32  read data; 0 for writes.
- `resp_err`  out  1  slave error, or timeout error.
- `out_paddr`, `out_pwdata`  out  32  APB address and write data.
- `out_psel`, `out_penable`, `out_pwrite`  out  1  APB select, enable and write.
- `out_pprot`  out  3  APB protection.
- `out_pstrb`  out  4  APB strobes.
- `out_pready`, `out_pslverr`  in  1  APB ready and slave error.
- `out_prdata`  in  32  APB read data.

## Operation
- State machine with four states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` is high, latch addr, write, wdata, wstrb and prot, then go to SETUP.
  - If the request is a read, latch wstrb as 4'b0000 (APB4 rule).
- SETUP: `out_psel`=1, `out_penable`=0. Lasts exactly one cycle, then go to ACCESS.
- ACCESS:
  - `out_psel`=1, `out_penable`=1.
  - When `out_pready` is high:
    - Capture `out_prdata` into `resp_rdata` for reads; force 0 for writes.
    - Capture `out_pslverr` into `resp_err`.
    - Go to RESP.
- RESP:
  - `resp_valid`=1 and `out_psel`=0.
  - When `resp_ready` is high, go to IDLE.
  - `req_ready` is 0 in this state; there is no request pass-through.
- `out_paddr`, `out_pwrite`, `out_pwdata`, `out_pstrb` and `out_pprot` are driven from the latched registers. They stay stable from SETUP through the end of ACCESS.
- `req_ready` is 1 only in IDLE. The response registers hold their values until the next ACCESS completion.

## Timing
- Reset values:
  - `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `out_psel`=0, `out_penable`=0.
  - `out_paddr`, `out_pwdata`, `out_pstrb`, `out_pprot` and `out_pwrite` all 0.
- Request handshake at edge N:
  - SETUP during cycle N+1.
  - ACCESS starts in cycle N+2.
  - If `out_pready` is high in cycle N+2+k, `resp_valid` rises in cycle N+3+k.
- Minimum issue interval between back-to-back transfers is 4 cycles (zero-wait completer, `resp_ready` tied high).
- `out_pready` is ignored outside ACCESS.
- `resp_ready` is ignored outside RESP.
- Reset asserted mid-transfer: at the next edge the block returns to IDLE, `out_psel`/`out_penable` drop, and the transfer is lost with no response.
- `resp_valid` high with `resp_ready` low: hold the response and stay in RESP indefinitely.

## Configuration
- Macro: `APB_REQ_BRIDGE_TIMEOUT_EN`.
- When defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle without `out_pready`.
  - If the counter reaches `TIMEOUT_CYCLES`-1 while `out_pready` is still low, the block goes to RESP with `resp_err`=1 and `resp_rdata`=0, and `out_psel` drops.
  - The ACCESS phase is therefore never longer than `TIMEOUT_CYCLES` cycles.
  - This abandons an APB transfer on purpose. It is a debug/hang-containment feature.
- When undefined: no counter is built and ACCESS waits indefinitely.

## Structure
- Package `apb_req_bridge_pkg` holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - the APB widths (ADDR 32, DATA 32, STRB 4, PROT 3).
- Optional sub-module `apb_timeout_counter`:
  - Width is `$clog2(TIMEOUT_CYCLES)`.
  - Inputs: `clear`, `enable`. Output: `expired`.
  - Instantiated only under the macro.

## Test plan
- Zero-wait read of 0x1000_0004 with `out_prdata`=0xDEADBEEF and `resp_ready` high:
  - psel high for cycles N+1 and N+2; penable high in N+2 only;
  - `resp_valid` in N+3 with rdata 0xDEADBEEF and err 0.
- Write of 0x55AA_1234 with wstrb 4'b0011 and `out_pready` delayed 5 cycles:
  - addr, wdata and pstrb stable for 7 cycles;
  - response has rdata 0 and err 0.
- Read with `out_pslverr`=1 at pready: `resp_err`=1. Read sets `out_pstrb`=0 regardless of `req_wstrb`=4'hF.
- `resp_ready` held low for 10 cycles: `resp_valid` and data held, `req_ready`=0, psel=0; completes on the first `resp_ready` high.
- Reset pulsed in ACCESS: next cycle psel=0, `resp_valid`=0, `req_ready`=1; a new request proceeds normally.
- With `APB_REQ_BRIDGE_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8 and pready never asserted:
  - ACCESS lasts 8 cycles;
  - `resp_err`=1 and rdata 0;
  - psel drops.
